ina220_poll_seq: RTL

INA220_POLL_SEQ -- requirements
Module: ina220_poll_seq

---
 rtl/ina220_pkg.sv | 27 ++
 rtl/ina220_tick_gen.sv | 19 +
 rtl/ina220_poll_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ina220_pkg.sv
// Shared definitions for the INA220 poll sequencer: register pointers and FSM state encoding.
package ina220_pkg;

    localparam logic [7:0] PTR_CFG   = 8'h00;
    localparam logic [7:0] PTR_SHUNT = 8'h01;
    localparam logic [7:0] PTR_BUS   = 8'h02;
    localparam logic [7:0] PTR_POWER = 8'h03;
    localparam logic [7:0] PTR_CURR  = 8'h04;
    localparam logic [7:0] PTR_CAL   = 8'h05;

    typedef enum logic [2:0] {
        ST_INIT_CFG,
        ST_WAIT_CFG,
        ST_INIT_CAL,
        ST_WAIT_CAL,
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_COMMIT
    } state_e;

    // Shadow slot for a measurement pointer: SHUNT..CURR map to 0..3.
    function automatic logic [1:0] slot_of(input logic [7:0] ptr);
        return 2'(ptr - PTR_SHUNT);
    endfunction

endpackage

// File: rtl/ina220_tick_gen.sv
// Free-running poll divider: counts 0..DIV-1 and pulses tick on the wrap cycle.
module ina220_tick_gen #(
    parameter int unsigned DIV = 500000
) (
    input  logic PCLK,
    input  logic PRESET,
    output logic tick
);

    logic [31:0] cnt;

    assign tick = (cnt == DIV - 1);

    always_ff @(posedge PCLK) begin
        if (PRESET) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 32'd1;
    end

endmodule

// File: rtl/ina220_poll_seq.sv
// INA220 sequencer: writes config/calibration once, then periodically reads regs 0x01..0x04
// through an external IIC master and publishes them as one coherent frame.
module ina220_poll_seq
    import ina220_pkg::*;
#(
    parameter int unsigned POLL_DIV = 500000,
    parameter int unsigned TIMEOUT  = 100000,
    parameter logic [15:0] CFG_WORD = 16'h399F,
    parameter logic [15:0] CAL_WORD = 16'h1000
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        ENABLE,
    input  logic        IIC_DONE,
    input  logic        WE_OUT,
    input  logic [23:0] OUT_DATA,
    output logic        WE,
    output logic        RE,
    output logic [7:0]  DATA_IN_0,
    output logic [15:0] DATA_IN_1,
    output logic [15:0] SHUNT_V,
    output logic [15:0] BUS_V,
    output logic [15:0] POWER,
    output logic [15:0] CURRENT,
    output logic        FRAME_VALID,
    output logic        ERR
);

    state_e      state, state_nxt;
    logic [7:0]  ptr, ptr_nxt;
    logic [7:0]  din0_nxt;
    logic [15:0] din1_nxt;
    logic        we_nxt, re_nxt;
    logic        err_set, to_clr, shadow_we, commit;
    logic        tick, waiting, to_expired;
    logic [31:0] to_cnt;
    logic [15:0] shadow [4];

    ina220_tick_gen #(.DIV(POLL_DIV)) u_tick (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .tick   (tick)
    );

    assign waiting    = (state == ST_WAIT_CFG) || (state == ST_WAIT_CAL) || (state == ST_RD_WAIT);
    assign to_expired = waiting && (to_cnt == TIMEOUT - 1);

    // NOTE: registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= ST_INIT_CFG;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        din0_nxt  = DATA_IN_0;
        din1_nxt  = DATA_IN_1;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        err_set   = 1'b0;
        to_clr    = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_INIT_CFG: begin
                we_nxt    = 1'b1;
                din0_nxt  = PTR_CFG;
                din1_nxt  = CFG_WORD;
                to_clr    = 1'b1;
                state_nxt = ST_WAIT_CFG;
            end
            ST_WAIT_CFG: begin
                if (IIC_DONE) state_nxt = ST_INIT_CAL;
                else if (to_expired) begin
                    err_set   = 1'b1;
                    state_nxt = ST_INIT_CFG;
                end
            end
            ST_INIT_CAL: begin
                we_nxt    = 1'b1;
                din0_nxt  = PTR_CAL;
                din1_nxt  = CAL_WORD;
                to_clr    = 1'b1;
                state_nxt = ST_WAIT_CAL;
            end
            ST_WAIT_CAL: begin
                if (IIC_DONE) state_nxt = ST_IDLE;
                else if (to_expired) begin
                    err_set   = 1'b1;
                    state_nxt = ST_INIT_CAL;
                end
            end
            ST_IDLE: begin
                if (tick && ENABLE) begin
                    ptr_nxt   = PTR_SHUNT;
                    state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                re_nxt    = 1'b1;
                din0_nxt  = ptr;
                to_clr    = 1'b1;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // A reply for the wrong register means the bus lost sync; drop the whole round.
                if (WE_OUT) begin
                    if (OUT_DATA[23:16] == ptr) begin
                        shadow_we = 1'b1;
                        if (ptr == PTR_CURR) state_nxt = ST_COMMIT;
                        else begin
                            ptr_nxt   = ptr + 8'd1;
                            state_nxt = ST_RD_REQ;
                        end
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (to_expired) begin
                    err_set   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_INIT_CFG;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            WE          <= 1'b0;
            RE          <= 1'b0;
            DATA_IN_0   <= PTR_CFG;
            DATA_IN_1   <= 16'h0000;
            ptr         <= PTR_CFG;
            to_cnt      <= '0;
            SHUNT_V     <= 16'h0000;
            BUS_V       <= 16'h0000;
            POWER       <= 16'h0000;
            CURRENT     <= 16'h0000;
            FRAME_VALID <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            WE          <= we_nxt;
            RE          <= re_nxt;
            DATA_IN_0   <= din0_nxt;
            DATA_IN_1   <= din1_nxt;
            ptr         <= ptr_nxt;
            FRAME_VALID <= commit;
            if (to_clr)       to_cnt <= '0;
            else if (waiting) to_cnt <= to_cnt + 32'd1;
            if (err_set) ERR <= 1'b1;
            if (commit) begin
                SHUNT_V <= shadow[0];
                BUS_V   <= shadow[1];
                POWER   <= shadow[2];
                CURRENT <= shadow[3];
            end
        end
    end

    // NOTE: the shadow slots carry no reset; COMMIT is only reachable after all four were rewritten.
    always_ff @(posedge PCLK) begin
        if (shadow_we) shadow[slot_of(ptr)] <= OUT_DATA[15:0];
    end

endmodule
